// File: rtl/io_port_bridge_if.sv
// ---------------------------------------------------------------------------
// io_port_bridge_if
// Groups the processor-side and host-side data/handshake signals of the
// io_port_bridge.
//
// Handshake rules (one word moves per clock edge in each direction):
//   - host_tx: a word transfers on a rising edge where host_tx_valid and
//     host_tx_ready are both 1. While valid=1 and ready=0, the data and valid
//     stay unchanged.
//   - host_rx: a word transfers on a rising edge where host_rx_valid and
//     host_rx_ready are both 1. When ready=0, the sender holds its word and
//     offers it again.
//   - cpu_out_we / cpu_in_re are single-cycle strobes with no back-pressure.
//     A write while cpu_out_full=1 with no same-cycle drain is dropped.
//     A read while cpu_in_valid=0 does nothing except flag an underflow.
//
// Modports:
//   master : the environment, i.e. the processor plus the host.
//   slave  : the bridge.
// ---------------------------------------------------------------------------
interface io_port_bridge_if #(
  parameter int W = 16
);
  logic [W-1:0] cpu_out_data;
  logic         cpu_out_we;
  logic         cpu_out_full;
  logic [W-1:0] cpu_in_data;
  logic         cpu_in_valid;
  logic         cpu_in_re;
  logic [W-1:0] host_tx_data;
  logic         host_tx_valid;
  logic         host_tx_ready;
  logic [W-1:0] host_rx_data;
  logic         host_rx_valid;
  logic         host_rx_ready;

  modport master (
    output cpu_out_data, cpu_out_we, cpu_in_re,
    output host_tx_ready, host_rx_data, host_rx_valid,
    input  cpu_out_full, cpu_in_data, cpu_in_valid,
    input  host_tx_data, host_tx_valid, host_rx_ready
  );

  modport slave (
    input  cpu_out_data, cpu_out_we, cpu_in_re,
    input  host_tx_ready, host_rx_data, host_rx_valid,
    output cpu_out_full, cpu_in_data, cpu_in_valid,
    output host_tx_data, host_tx_valid, host_rx_ready
  );
endinterface

// File: rtl/io_port_bridge.sv
// ---------------------------------------------------------------------------
// io_port_bridge
// Bridges processor OUT/IN instructions to a valid/ready host link.
//   TX path: CPU OUT strobe -> TX FIFO -> registered output stage -> host.
//   RX path: host -> RX FIFO (first-word-fall-through) -> CPU IN strobe.
// Sticky error flags record dropped CPU writes (ovf_err) and reads from an
// empty RX FIFO (udf_err). err_clr clears both flags. If a new error event
// happens in the same cycle as err_clr, the new event wins.
//
// Ports:
//   clk, rst      : clock and synchronous active-high reset.
//   bus           : io_port_bridge_if.slave (cpu_* and host_* signals).
//   err_clr       : clears the sticky error flags.
//   ovf_err       : sticky flag, a CPU write was dropped.
//   udf_err       : sticky flag, a CPU read found the RX FIFO empty.
//   dbg_tx_state  : TX output-stage FSM state (0 = EMPTY, 1 = LOADED).
//
// Parameters:
//   DEPTH : entries per FIFO. Must be a power of two and at least 2.
//   W     : data word width. Must match the W of the bus interface.
// ---------------------------------------------------------------------------
module io_port_bridge #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  io_port_bridge_if.slave     bus,
  input  logic                err_clr,
  output logic                ovf_err,
  output logic                udf_err,
  output logic                dbg_tx_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic {
    TX_EMPTY  = 1'b0,
    TX_LOADED = 1'b1
  } tx_state_e;

  // ---------------------------------------------------------------- TX FIFO
  logic [W-1:0]  tx_mem_q [DEPTH];
  logic [W-1:0]  tx_mem_d [DEPTH];
  logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [PW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_full;
  logic          tx_nonempty;
  logic          tx_push;
  logic          tx_pop;
  logic          ovf_event;

  // --------------------------------------------------------- TX output stage
  tx_state_e     tx_state_q, tx_state_d;
  logic [W-1:0]  tx_data_q, tx_data_d;
  logic          tx_valid;

  // ---------------------------------------------------------------- RX FIFO
  logic [W-1:0]  rx_mem_q [DEPTH];
  logic [W-1:0]  rx_mem_d [DEPTH];
  logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [PW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          rx_ready;
  logic          rx_nonempty;
  logic          rx_push;
  logic          rx_pop;
  logic          udf_event;

  // ------------------------------------------------------------- error flags
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  // ========================================================================
  // TX output stage FSM, process 1 of 3: state register. The stage data
  // register sits here too because it changes only when the FSM pops.
  // ========================================================================
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_EMPTY;
      tx_data_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // TX output stage FSM, process 2 of 3: next-state logic.
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_EMPTY:  if (tx_nonempty) tx_state_d = TX_LOADED;
      TX_LOADED: if (bus.host_tx_ready && !tx_nonempty) tx_state_d = TX_EMPTY;
      default:   tx_state_d = TX_EMPTY;
    endcase
  end

  // TX output stage FSM, process 3 of 3: outputs.
  // In the LOADED state with ready=1, the stage pops the FIFO head in the
  // same edge that the host takes the current word. This keeps a steady
  // stream at one word per cycle.
  always_comb begin
    tx_valid = 1'b0;
    tx_pop   = 1'b0;
    case (tx_state_q)
      TX_EMPTY: begin
        tx_pop = tx_nonempty;
      end
      TX_LOADED: begin
        tx_valid = 1'b1;
        tx_pop   = bus.host_tx_ready && tx_nonempty;
      end
      default: begin
        tx_valid = 1'b0;
        tx_pop   = 1'b0;
      end
    endcase
  end

  always_comb begin
    tx_data_d = tx_data_q;
    if (tx_pop) tx_data_d = tx_mem_q[tx_rd_ptr_q];
  end

  // ========================================================================
  // TX FIFO
  // ========================================================================
  assign tx_full     = (tx_cnt_q == CNT_FULL);
  assign tx_nonempty = (tx_cnt_q != '0);

  // A full FIFO still takes a write when the stage drains a word in the
  // same cycle. A write into an empty FIFO is never forwarded straight to
  // the stage, so the first word becomes valid one edge after the push edge.
  assign tx_push   = bus.cpu_out_we && (!tx_full || tx_pop);
  assign ovf_event = bus.cpu_out_we && !tx_push;

  always_comb begin
    tx_mem_d    = tx_mem_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_ptr_q] = bus.cpu_out_data;
      tx_wr_ptr_d           = tx_wr_ptr_q + PTR_ONE;
    end
    if (tx_pop) begin
      tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
    end
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  // ========================================================================
  // RX FIFO
  // ========================================================================
  assign rx_ready    = (rx_cnt_q != CNT_FULL);
  assign rx_nonempty = (rx_cnt_q != '0);
  assign rx_push     = bus.host_rx_valid && rx_ready;
  assign rx_pop      = bus.cpu_in_re && rx_nonempty;
  assign udf_event   = bus.cpu_in_re && !rx_nonempty;

  always_comb begin
    rx_mem_d    = rx_mem_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    if (rx_push) begin
      rx_mem_d[rx_wr_ptr_q] = bus.host_rx_data;
      rx_wr_ptr_d           = rx_wr_ptr_q + PTR_ONE;
    end
    if (rx_pop) begin
      rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
    end
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // ========================================================================
  // Sticky error flags. A new event takes priority over err_clr.
  // ========================================================================
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (ovf_event) ovf_d = 1'b1;
    if (udf_event) udf_d = 1'b1;
  end

  // ========================================================================
  // FIFO and flag registers. Reset overrides any strobe in the same cycle.
  // ========================================================================
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      tx_mem_q    <= tx_mem_d;
      rx_mem_q    <= rx_mem_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  // ========================================================================
  // Outputs
  // ========================================================================
  assign bus.cpu_out_full  = tx_full;
  assign bus.host_tx_data  = tx_data_q;
  assign bus.host_tx_valid = tx_valid;
  assign bus.host_rx_ready = rx_ready;
  assign bus.cpu_in_valid  = rx_nonempty;
  // The RX output reads as zero when the FIFO is empty, so a stale word
  // never reaches the processor's data_in.
  assign bus.cpu_in_data   = rx_nonempty ? rx_mem_q[rx_rd_ptr_q] : '0;
  assign ovf_err           = ovf_q;
  assign udf_err           = udf_q;
  assign dbg_tx_state      = tx_state_q;

endmodule
